// File: rtl/ibsg_rate.sv
// Rate-coded bitstream generator: compares a latched magnitude against the
// bit-reversed stream index to emit exactly data_q ones over 2^WIDTH enabled cycles.
module ibsg_rate #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i_data,
    input  logic             hold,
    input  logic             abort,
    output logic             o_bit,
    output logic             o_en,
    output logic             o_clr,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start, outputs quiet
    // CLR   | one-cycle clear pulse to the downstream register
    // RUN   | streaming; hold stalls the index and suppresses o_en
    // DONE  | one-cycle completion pulse, start not accepted
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cnt_rev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Bit-reversed index spreads the ones evenly across the stream.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_rev[i] = cnt_q[WIDTH-1-i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        o_bit   = 1'b0;
        o_en    = 1'b0;
        o_clr   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLR;
                    data_d  = i_data;
                    cnt_d   = '0;
                end
            end
            S_CLR: begin
                o_clr   = 1'b1;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // hold gates o_en in the same cycle the index freezes, so the
                // downstream register never sees an enable without an advance.
                if (!hold) begin
                    o_en  = 1'b1;
                    o_bit = (data_q > cnt_rev);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ibsg_rate.sv
// Self-checking bench for ibsg_rate: directed streams with randomized data,
// hold and start noise, checked against a per-index reference of the coding rule.
module tb_ibsg_rate;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] i_data;
    logic         hold;
    logic         abort;
    logic         o_bit;
    logic         o_en;
    logic         o_clr;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    ibsg_rate #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .i_data (i_data),
        .hold   (hold),
        .abort  (abort),
        .o_bit  (o_bit),
        .o_en   (o_en),
        .o_clr  (o_clr),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            if (((k >> i) & 1) != 0) r |= (1 << (W - 1 - i));
        end
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en"},   o_en, 0);
        check({tag, "_clr"},  o_clr, 0);
        check({tag, "_bit"},  o_bit, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // stop_kind: 0 = run to completion, 1 = abort at index stop_at, 2 = reset at stop_at
    task automatic stream(input int d, input int hold_at, input int hold_len,
                          input bit rand_hold, input bit noise,
                          input int stop_at, input int stop_kind);
        int  k = 0;
        int  held = 0;
        int  nholds = 0;
        int  ones = 0;
        int  run_cyc = 0;
        int  exp_bit;
        bit  h;
        bit  seen_done;

        @(negedge clk);
        i_data = W'(d); start = 1'b1; hold = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0; i_data = W'($urandom);
        #1;
        check("clr_pulse", o_clr, 1);
        check("clr_en",    o_en, 0);
        check("clr_busy",  busy, 1);

        while (k < N && run_cyc < 4 * N) begin
            @(negedge clk);
            if (stop_kind != 0 && k == stop_at) begin
                hold = 1'b0; start = 1'b0;
                if (stop_kind == 1) abort = 1'b1; else rst = 1'b1;
                @(negedge clk);
                abort = 1'b0; rst = 1'b0;
                #1;
                check_quiet(stop_kind == 1 ? "abort" : "midrst");
                seen_done = 1'b0;
                repeat (N + 4) begin
                    @(negedge clk);
                    #1;
                    seen_done |= done | busy;
                end
                check("stopped_no_done", seen_done, 0);
                return;
            end
            if (k == hold_at && held < hold_len) begin
                h = 1'b1;
                held++;
            end else begin
                h = rand_hold && ($urandom_range(0, 3) == 0);
            end
            hold = h;
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                i_data = W'(5);
            end
            #1;
            exp_bit = (!h && d > bitrev(k)) ? 1 : 0;
            check("run_en",   o_en, h ? 0 : 1);
            check("run_bit",  o_bit, exp_bit);
            check("run_clr",  o_clr, 0);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            if (o_en === 1'b1 && o_bit === 1'b1) ones++;
            if (h) nholds++; else k++;
            run_cyc++;
        end
        check("run_timeout", k, N);

        @(negedge clk);
        hold = 1'b0;
        start = noise;
        i_data = W'(5);
        #1;
        check("done_pulse", done, 1);
        check("done_en",    o_en, 0);
        check("done_bit",   o_bit, 0);
        check("done_clr",   o_clr, 0);
        check("done_busy",  busy, 1);
        check("ones_total", ones, d);
        check("run_length", run_cyc, N + nholds);

        @(negedge clk);
        start = 1'b0;
        #1;
        check_quiet("after_done");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        // abort in IDLE blocks start
        @(negedge clk);
        start = 1'b1; abort = 1'b1; i_data = W'(9);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check_quiet("idle_abort");

        stream(0,   -1, 0, 1'b0, 1'b0, -1, 0);
        stream(255, -1, 0, 1'b0, 1'b0, -1, 0);
        stream(128, -1, 0, 1'b0, 1'b0, -1, 0);
        stream(77,  40, 3, 1'b0, 1'b0, -1, 0);
        stream(99,  -1, 0, 1'b0, 1'b0, 10, 1);
        stream(77,  -1, 0, 1'b0, 1'b0, -1, 0);
        stream(200, -1, 0, 1'b0, 1'b1, -1, 0);
        stream(163, -1, 0, 1'b0, 1'b0, 100, 2);
        stream(31,  -1, 0, 1'b0, 1'b0, -1, 0);
        for (int r = 0; r < 3; r++) begin
            stream(int'($urandom_range(0, N - 1)), -1, 0, 1'b1, 1'b1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
